// File: rtl/div_pkg.sv
// Shared types for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/adder_9.sv
// Ripple adder/subtractor shared with the multiplier datapath; sub_i=1 gives a_i - b_i.
module adder_9 #(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] sum_o
);

  assign sum_o = a_i + (b_i ^ {N{sub_i}}) + {{(N-1){1'b0}}, sub_i};

endmodule

// File: rtl/divider_unit.sv
// Sequential signed restoring divider: one shift-subtract step per cycle on magnitudes,
// with sign fixup at the end. Truncates toward zero; remainder takes the dividend's sign.
module divider_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero,
  output logic             Overflow,
  output logic [1:0]       StateDbg
);

  // Handshake: Start is a level request accepted only in IDLE; operands are sampled on that
  // edge. Done stays high in DONE until Start drops, so a held Start yields one operation.

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             sn_q, sn_d, sd_q, sd_d, ovc_q, ovc_d;
  logic             dbz_q, dbz_d, ovf_q, ovf_d;

  logic [WIDTH-1:0] r_sh, q_sh;
  logic [WIDTH:0]   trial;

  // Unsigned magnitude: the most negative value maps to 2^(WIDTH-1) exactly.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  assign {r_sh, q_sh} = {r_q, q_q} << 1;

  adder_9 #(.N(WIDTH + 1)) u_trial (
    .a_i  ({1'b0, r_sh}),
    .b_i  ({1'b0, d_q}),
    .sub_i(1'b1),
    .sum_o(trial)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      sn_q    <= 1'b0;
      sd_q    <= 1'b0;
      ovc_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      sn_q    <= sn_d;
      sd_q    <= sd_d;
      ovc_q   <= ovc_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    sn_d    = sn_q;
    sd_d    = sd_q;
    ovc_d   = ovc_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (Divisor != '0) begin
            sn_d    = Dividend[WIDTH-1];
            sd_d    = Divisor[WIDTH-1];
            ovc_d   = (Dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&Divisor);
            r_d     = '0;
            q_d     = mag(Dividend);
            d_d     = mag(Divisor);
            cnt_d   = '0;
            state_d = STEP;
          end else begin
            quot_d  = '1;
            rem_d   = Dividend;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      STEP: begin
        // A clear borrow bit means the shifted remainder covers the divisor.
        q_d   = {q_sh[WIDTH-1:1], ~trial[WIDTH]};
        r_d   = trial[WIDTH] ? r_sh : trial[WIDTH-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIXUP;
      end
      FIXUP: begin
        quot_d  = (sn_q ^ sd_q) ? -q_q : q_q;
        rem_d   = sn_q ? -r_q : r_q;
        ovf_d   = ovc_q;
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (!Start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy      = (state_q == STEP) || (state_q == FIXUP);
  assign Done      = (state_q == DONE);
  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign DivByZero = dbz_q;
  assign Overflow  = ovf_q;
  assign StateDbg  = state_q;

endmodule

// File: tb/tb_divider_unit.sv
// Bench for divider_unit: directed table, randomized ops against an integer-arithmetic model,
// and hand-written held-Start and mid-operation reset sequences.
module tb_divider_unit;
  import div_pkg::*;

  localparam int W  = 8;
  localparam int EW = 2 * W + 2;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] Dividend = '0;
  logic [W-1:0] Divisor = '0;
  logic         Busy, Done, DivByZero, Overflow;
  logic [W-1:0] Quotient, Remainder;
  logic [1:0]   StateDbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } vec_t;

  vec_t vecs[6];

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  divider_unit #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Busy     (Busy),
    .Done     (Done),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .DivByZero(DivByZero),
    .Overflow (Overflow),
    .StateDbg (StateDbg)
  );

  // ---------------- checker / model ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected {quotient, remainder, divbyzero, overflow} from plain signed arithmetic.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, qi, ri;
    logic [W-1:0] q8, r8;
    logic ovf;
    if (b == '0) return {{W{1'b1}}, a, 1'b1, 1'b0};
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    qi  = sa / sb;
    ri  = sa % sb;
    q8  = qi[W-1:0];
    r8  = ri[W-1:0];
    ovf = (sa == -(2 ** (W - 1))) && (sb == -1);
    return {q8, r8, 1'b0, ovf};
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat_o, output logic saw_busy_o);
    int n;
    n = 0;
    saw_busy_o = 1'b0;
    @(negedge Clk);
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    do begin
      @(negedge Clk);
      n++;
      if (Busy) saw_busy_o = 1'b1;
      check("busy_done_exclusive", 32'(Busy & Done), 32'd0);
    end while (!Done && n < 40);
    check("done_seen", 32'(Done), 32'd1);
    lat_o = n;
    Start    = 1'b0;
    Dividend = 8'($urandom);
    Divisor  = 8'($urandom);
    @(negedge Clk);
    check("done_falls_after_start", 32'(Done), 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int lat, rises, done_rises;
    logic saw_busy, prev_busy, prev_done;
    logic [W-1:0] a, b;
    logic [EW-1:0] e;

    vecs[0] = '{8'h07, 8'h02, 8'h03, 8'h01, 1'b0, 1'b0, 10};
    vecs[1] = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 10};
    vecs[2] = '{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0, 10};
    vecs[3] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 10};
    vecs[4] = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 10};
    vecs[5] = '{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0, 1};

    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_quotient", 32'(Quotient), 32'd0);
    check("rst_remainder", 32'(Remainder), 32'd0);
    check("rst_flags", 32'({Busy, Done, DivByZero, Overflow}), 32'd0);
    check("rst_state", 32'(StateDbg), 32'(IDLE));
    Reset_n = 1'b1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat, saw_busy);
      check($sformatf("tbl%0d_quotient", i), 32'(Quotient), 32'(vecs[i].q));
      check($sformatf("tbl%0d_remainder", i), 32'(Remainder), 32'(vecs[i].r));
      check($sformatf("tbl%0d_divbyzero", i), 32'(DivByZero), 32'(vecs[i].dbz));
      check($sformatf("tbl%0d_overflow", i), 32'(Overflow), 32'(vecs[i].ovf));
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("tbl%0d_busy_seen", i), 32'(saw_busy), 32'(!vecs[i].dbz));
    end

    // Randomized against the model
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0: b = 8'h00;
        1: begin a = 8'h80; b = 8'hFF; end
        2: a = 8'h80;
        default: ;
      endcase
      exp_q.push_back(model(a, b));
      run_op(a, b, lat, saw_busy);
      e = exp_q.pop_front();
      check($sformatf("rnd%0d_%02h_%02h_result", i, a, b),
            32'({Quotient, Remainder, DivByZero, Overflow}), 32'(e));
      check($sformatf("rnd%0d_latency", i), 32'(lat), (b == '0) ? 32'd1 : 32'(W + 2));
    end

    // Held Start: one operation only, operand changes after accept ignored
    @(negedge Clk);
    Dividend = 8'd100;
    Divisor  = 8'd7;
    Start    = 1'b1;
    rises = 0;
    done_rises = 0;
    prev_busy = Busy;
    prev_done = Done;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (Busy && !prev_busy) rises++;
      if (Done && !prev_done) done_rises++;
      prev_busy = Busy;
      prev_done = Done;
      Dividend = 8'($urandom);
      Divisor  = 8'($urandom);
    end
    check("held_busy_rises", 32'(rises), 32'd1);
    check("held_done_rises", 32'(done_rises), 32'd1);
    check("held_done_high", 32'(Done), 32'd1);
    check("held_quotient", 32'(Quotient), 32'h0E);
    check("held_remainder", 32'(Remainder), 32'h02);
    Start = 1'b0;
    @(negedge Clk);
    check("held_done_falls", 32'(Done), 32'd0);
    run_op(8'd100, 8'd7, lat, saw_busy);
    check("restart_quotient", 32'(Quotient), 32'h0E);
    check("restart_latency", 32'(lat), 32'(W + 2));

    // Asynchronous reset during STEP cycle 4
    @(negedge Clk);
    Dividend = 8'd100;
    Divisor  = 8'd7;
    Start    = 1'b1;
    repeat (4) @(negedge Clk);
    check("pre_reset_busy", 32'(Busy), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("mid_rst_quotient", 32'(Quotient), 32'd0);
    check("mid_rst_remainder", 32'(Remainder), 32'd0);
    check("mid_rst_flags", 32'({Busy, Done, DivByZero, Overflow}), 32'd0);
    check("mid_rst_state", 32'(StateDbg), 32'(IDLE));
    Start = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    run_op(8'd9, 8'd3, lat, saw_busy);
    check("post_rst_quotient", 32'(Quotient), 32'h03);
    check("post_rst_remainder", 32'(Remainder), 32'h00);
    check("post_rst_latency", 32'(lat), 32'(W + 2));

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
